// File: rtl/aes_round_scheduler_pkg.sv
// aes_round_scheduler_pkg: shared constants and FSM encoding for the AES-128 round scheduler
package aes_round_scheduler_pkg;
    localparam int AES_NUM_ROUNDS = 10;
    localparam int RK_W = 4;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEYWAIT = 2'd1,
        ROUND   = 2'd2,
        DONE    = 2'd3
    } sched_state_e;
endpackage

// File: rtl/aes_round_scheduler.sv
// aes_round_scheduler: sequences key expansion, block acceptance, round controls and ciphertext release
module aes_round_scheduler
    import aes_round_scheduler_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            key_load_req,
    output logic            key_load,
    input  logic            key_ready,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            state_load,
    output logic            state_en,
    output logic            mixcol_en,
    output logic [RK_W-1:0] rk_addr,
    output logic            key_valid,
    output logic            busy
);
    localparam logic [RK_W-1:0] LAST = NUM_ROUNDS[RK_W-1:0];
    sched_state_e    state_q, state_d;
    logic [RK_W-1:0] round_q, round_d;
    logic            key_valid_q, key_valid_d;
    logic            key_pending_q, key_pending_d;
    logic            idle, key_req, accept, last_round;
    // Decode the datapath controls and handshakes from the current state and round
    always_comb begin
        idle       = state_q == IDLE;
        key_req    = key_load_req || key_pending_q;
        key_load   = idle && key_req;
        in_ready   = idle && !key_req && key_valid_q;
        accept     = in_ready && in_valid;
        state_load = accept;
        state_en   = state_q == ROUND;
        last_round = round_q == LAST;
        rk_addr    = state_en ? round_q : '0;
        mixcol_en  = state_en && !last_round;
        out_valid  = state_q == DONE;
        key_valid  = key_valid_q;
        busy       = !idle;
    end
    // Next state, round counter and key bookkeeping; a key request arriving mid-block waits in key_pending
    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        key_valid_d   = key_valid_q;
        key_pending_d = key_pending_q || (key_load_req && !idle);
        if (key_load) begin
            state_d       = KEYWAIT;
            key_valid_d   = 1'b0;
            key_pending_d = 1'b0;
        end else if (accept) begin
            state_d = ROUND;
            round_d = 4'd1;
        end
        if (state_q == KEYWAIT && key_ready) begin
            state_d     = IDLE;
            key_valid_d = 1'b1;
        end
        if (state_en) begin
            state_d = last_round ? DONE : ROUND;
            round_d = last_round ? '0 : round_q + 4'd1;
        end
        if (out_valid && out_ready) begin
            state_d = IDLE;
            round_d = '0;
        end
    end
    // State registers; reset aborts any block or expansion and forgets the key
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            round_q       <= '0;
            key_valid_q   <= 1'b0;
            key_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            key_valid_q   <= key_valid_d;
            key_pending_q <= key_pending_d;
        end
    end
endmodule

// File: tb/tb_aes_round_scheduler.sv
// tb_aes_round_scheduler: directed scenarios plus randomized run against a cycle-age reference model
module tb_aes_round_scheduler;
    localparam int NR = 10;
    logic clk = 1'b0;
    logic reset = 1'b1, key_load_req = 1'b0, key_ready = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic key_load, in_ready, out_valid, state_load, state_en, mixcol_en, key_valid, busy;
    logic [3:0] rk_addr;
    logic [11:0] obs;
    int cmp = 0;
    int errs = 0;

    always #5 clk = ~clk;

    aes_round_scheduler #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .reset(reset), .key_load_req(key_load_req), .key_load(key_load),
        .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .state_load(state_load), .state_en(state_en),
        .mixcol_en(mixcol_en), .rk_addr(rk_addr), .key_valid(key_valid), .busy(busy)
    );

    assign obs = {key_load, in_ready, out_valid, state_load, state_en, mixcol_en, rk_addr, key_valid, busy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input int lat);
        key_load_req = 1'b1;
        step();
        key_load_req = 1'b0;
        repeat (lat) step();
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        #1;
        cmp++;
        if (obs !== 12'h0) begin errs++; $display("FAIL reset_state: got %h exp 000", obs); end
        reset = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            cmp++;
            if (obs !== 12'h0) begin errs++; $display("FAIL no_key_refuse cyc %0d: got %h exp 000", i, obs); end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_key_load();
        int pulses;
        key_load_req = 1'b1;
        #1;
        cmp++;
        if (key_load !== 1'b1) begin errs++; $display("FAIL key_load_pulse: got %b exp 1", key_load); end
        step();
        key_load_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 21; i++) begin
            #1;
            pulses += int'(key_load);
            cmp++;
            if ({key_valid, busy, in_ready} !== 3'b010) begin
                errs++; $display("FAIL keywait cyc %0d: got kv/busy/ir %b exp 010", i, {key_valid, busy, in_ready});
            end
            step();
        end
        cmp++;
        if (pulses != 0) begin errs++; $display("FAIL key_load_single: got %0d extra pulses exp 0", pulses); end
        key_ready = 1'b1;
        #1;
        cmp++;
        if (key_valid !== 1'b0) begin errs++; $display("FAIL key_valid_early: got %b exp 0", key_valid); end
        step();
        key_ready = 1'b0;
        #1;
        cmp++;
        if ({key_valid, busy, in_ready} !== 3'b101) begin
            errs++; $display("FAIL key_valid_rise: got kv/busy/ir %b exp 101", {key_valid, busy, in_ready});
        end
    endtask

    task automatic test_block();
        out_ready = 1'b1;
        in_valid = 1'b1;
        #1;
        cmp++;
        if ({in_ready, state_load, state_en, rk_addr} !== 7'b1100000) begin
            errs++; $display("FAIL block_accept: got %b exp 1100000", {in_ready, state_load, state_en, rk_addr});
        end
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= NR; k++) begin
            #1;
            cmp++;
            if ({state_en, rk_addr, mixcol_en, out_valid, state_load} !== {1'b1, 4'(k), k != NR, 2'b00}) begin
                errs++;
                $display("FAIL round %0d: got en/rk/mc/ov/sl %b exp %b", k,
                         {state_en, rk_addr, mixcol_en, out_valid, state_load}, {1'b1, 4'(k), k != NR, 2'b00});
            end
            step();
        end
        #1;
        cmp++;
        if ({out_valid, state_en, busy, in_ready} !== 4'b1010) begin
            errs++; $display("FAIL out_valid_t11: got ov/en/busy/ir %b exp 1010", {out_valid, state_en, busy, in_ready});
        end
        step();
        #1;
        cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errs++; $display("FAIL ready_t12: got ov/ir %b exp 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        accepts = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 36; i++) begin
            #1;
            accepts += int'(state_load);
            if (i % 12 == 0) begin
                cmp++;
                if (state_load !== 1'b1) begin errs++; $display("FAIL b2b_accept cyc %0d: got %b exp 1", i, state_load); end
            end
            step();
        end
        in_valid = 1'b0;
        cmp++;
        if (accepts != 3) begin errs++; $display("FAIL b2b_throughput: got %0d exp 3", accepts); end
        repeat (12) step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        #1;
        cmp++;
        if (state_load !== 1'b1) begin errs++; $display("FAIL bp_accept: got %b exp 1", state_load); end
        step();
        in_valid = 1'b0;
        repeat (NR) step();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            cmp++;
            if ({out_valid, busy, in_ready, state_load} !== 4'b1100) begin
                errs++; $display("FAIL bp_hold cyc %0d: got ov/busy/ir/sl %b exp 1100", i, {out_valid, busy, in_ready, state_load});
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        cmp++;
        if ({out_valid, in_ready} !== 2'b10) begin errs++; $display("FAIL bp_release: got ov/ir %b exp 10", {out_valid, in_ready}); end
        step();
        in_valid = 1'b0;
        #1;
        cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin errs++; $display("FAIL bp_ready_t17: got ov/ir %b exp 01", {out_valid, in_ready}); end
    endtask

    task automatic test_key_during_block();
        out_ready = 1'b1;
        in_valid = 1'b1;
        #1;
        cmp++;
        if (state_load !== 1'b1) begin errs++; $display("FAIL kdb_accept: got %b exp 1", state_load); end
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= NR; k++) begin
            key_load_req = (k == 4);
            #1;
            cmp++;
            if ({rk_addr, key_load, key_valid} !== {4'(k), 2'b01}) begin
                errs++; $display("FAIL kdb_round %0d: got rk/kl/kv %b exp %b", k, {rk_addr, key_load, key_valid}, {4'(k), 2'b01});
            end
            step();
        end
        key_load_req = 1'b0;
        #1;
        cmp++;
        if ({out_valid, key_valid, key_load} !== 3'b110) begin
            errs++; $display("FAIL kdb_done: got ov/kv/kl %b exp 110", {out_valid, key_valid, key_load});
        end
        step();
        in_valid = 1'b1;
        #1;
        cmp++;
        if ({key_load, in_ready, state_load} !== 3'b100) begin
            errs++; $display("FAIL kdb_pending_load: got kl/ir/sl %b exp 100", {key_load, in_ready, state_load});
        end
        step();
        in_valid = 1'b0;
        #1;
        cmp++;
        if ({key_valid, busy, key_load} !== 3'b010) begin
            errs++; $display("FAIL kdb_key_dropped: got kv/busy/kl %b exp 010", {key_valid, busy, key_load});
        end
        repeat (3) step();
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        #1;
        cmp++;
        if (key_valid !== 1'b1) begin errs++; $display("FAIL kdb_rekey: got %b exp 1", key_valid); end
    endtask

    task automatic test_reset_abort();
        out_ready = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        #1;
        cmp++;
        if (obs !== 12'h0) begin errs++; $display("FAIL reset_abort: got %h exp 000", obs); end
        reset = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            cmp++;
            if ({in_ready, key_valid, state_load} !== 3'b000) begin
                errs++; $display("FAIL post_reset_refuse cyc %0d: got ir/kv/sl %b exp 000", i, {in_ready, key_valid, state_load});
            end
            step();
        end
        in_valid = 1'b0;
        load_key(2);
        #1;
        cmp++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL post_reset_rekey: got %b exp 1", in_ready); end
    endtask

    task automatic test_random();
        logic kv, pend, kw, idle, kl, ir, sl, rnd;
        int age;
        logic [11:0] exp_v;
        reset = 1'b1;
        step();
        reset = 1'b0;
        kv = 1'b0; pend = 1'b0; kw = 1'b0; age = 0;
        for (int i = 0; i < 3000; i++) begin
            key_load_req = $urandom_range(0, 24) == 0;
            key_ready = $urandom_range(0, 7) == 0;
            in_valid = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            idle = !kw && age == 0;
            kl = idle && (key_load_req || pend);
            ir = idle && !(key_load_req || pend) && kv;
            sl = ir && in_valid;
            rnd = age >= 1 && age <= NR;
            exp_v = {kl, ir, age > NR, sl, rnd, age >= 1 && age < NR, rnd ? 4'(age) : 4'd0, kv, !idle};
            #1;
            cmp++;
            if (obs !== exp_v) begin errs++; $display("FAIL random cyc %0d: got %b exp %b", i, obs, exp_v); end
            step();
            if (!idle && key_load_req) pend = 1'b1;
            if (kl) begin kv = 1'b0; pend = 1'b0; kw = 1'b1; end
            else if (kw && key_ready) begin kv = 1'b1; kw = 1'b0; end
            if (sl) age = 1;
            else if (rnd) age++;
            else if (age > NR && out_ready) age = 0;
        end
        key_load_req = 1'b0; key_ready = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_block();
        test_back_to_back();
        test_backpressure();
        test_key_during_block();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
